// File: rtl/bus_pkg.sv
// Shared constants for the two-master bus arbiter: FSM state codes,
// field widths, the timeout response pattern and master IDs.
package bus_pkg;

    localparam int BHW_W = 3;

    localparam logic [31:0] BUS_TIMEOUT_DATA = 32'hDEADBEEF;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/bus_req_buffer.sv
// One-entry request capture register for a single bus master. Holds the
// request until the arbiter has answered it and flags any request that
// arrives while the slot is occupied.
module bus_req_buffer
    import bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [31:0]      req_data,
    input  logic [31:0]      req_address,
    input  logic [BHW_W-1:0] req_bhw,
    input  logic             req_write_notread,
    input  logic             clear,
    output logic             pending,
    output logic [31:0]      data,
    output logic [31:0]      address,
    output logic [BHW_W-1:0] bhw,
    output logic             write_notread,
    output logic             drop
);

    // Pending flag: set by a request into an empty slot, cleared once answered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (req_valid && !pending) begin
            pending <= 1'b1;
        end
    end

    // Request fields are latched only when the slot is free, so a dropped
    // request never disturbs the one already waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data          <= '0;
            address       <= '0;
            bhw           <= '0;
            write_notread <= 1'b0;
        end else if (req_valid && !pending) begin
            data          <= req_data;
            address       <= req_address;
            bhw           <= req_bhw;
            write_notread <= req_write_notread;
        end
    end

    // One-cycle drop pulse, one cycle after a request hits an occupied slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop <= 1'b0;
        end else begin
            drop <= req_valid && pending;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of memory_top. One transaction is
// outstanding at a time; responses are routed back to the granted master and
// a dead slave is cut off after TIMEOUT wait cycles.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_m0_data,
    input  logic [31:0]      i_m0_address,
    input  logic             i_m0_DV,
    input  logic [BHW_W-1:0] i_m0_bhw,
    input  logic             i_m0_write_notread,
    input  logic [31:0]      i_m1_data,
    input  logic [31:0]      i_m1_address,
    input  logic             i_m1_DV,
    input  logic [BHW_W-1:0] i_m1_bhw,
    input  logic             i_m1_write_notread,
    output logic [31:0]      o_m0_data,
    output logic             o_m0_DV,
    output logic             o_m0_err,
    output logic [31:0]      o_m1_data,
    output logic             o_m1_DV,
    output logic             o_m1_err,
    output logic [31:0]      o_bus_data,
    output logic [31:0]      o_bus_address,
    output logic             o_bus_DV,
    output logic [BHW_W-1:0] o_bhw,
    output logic             o_write_notread,
    input  logic [31:0]      i_bus_data,
    input  logic             i_bus_DV,
    output logic             o_owner,
    output logic             o_busy
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             resp_err;

    logic             m0_pending, m1_pending;
    logic [31:0]      m0_buf_data, m0_buf_address, m1_buf_data, m1_buf_address;
    logic [BHW_W-1:0] m0_buf_bhw, m1_buf_bhw;
    logic             m0_buf_wnr, m1_buf_wnr;
    logic             m0_drop, m1_drop;
    logic             m0_clear, m1_clear;
    logic             grant_m1;

    assign m0_clear = (state == ST_RESP) && (o_owner == M_CPU);
    assign m1_clear = (state == ST_RESP) && (o_owner == M_AUX);

    bus_req_buffer u_m0_buf (
        .clk               (i_clk),
        .rst               (i_rst),
        .req_valid         (i_m0_DV),
        .req_data          (i_m0_data),
        .req_address       (i_m0_address),
        .req_bhw           (i_m0_bhw),
        .req_write_notread (i_m0_write_notread),
        .clear             (m0_clear),
        .pending           (m0_pending),
        .data              (m0_buf_data),
        .address           (m0_buf_address),
        .bhw               (m0_buf_bhw),
        .write_notread     (m0_buf_wnr),
        .drop              (m0_drop)
    );

    bus_req_buffer u_m1_buf (
        .clk               (i_clk),
        .rst               (i_rst),
        .req_valid         (i_m1_DV),
        .req_data          (i_m1_data),
        .req_address       (i_m1_address),
        .req_bhw           (i_m1_bhw),
        .req_write_notread (i_m1_write_notread),
        .clear             (m1_clear),
        .pending           (m1_pending),
        .data              (m1_buf_data),
        .address           (m1_buf_address),
        .bhw               (m1_buf_bhw),
        .write_notread     (m1_buf_wnr),
        .drop              (m1_drop)
    );

    // Round-robin pick: a lone requester wins, a tie goes to the master
    // that did not hold the bus last.
    always_comb begin
        grant_m1 = m1_pending && (!m0_pending || (o_owner == M_CPU));
    end

    // Transaction FSM: grant, issue one strobe, wait for the slave or the
    // timeout, then answer the owning master.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            resp_err        <= 1'b0;
            o_owner         <= M_AUX;
            o_bus_data      <= '0;
            o_bus_address   <= '0;
            o_bhw           <= '0;
            o_write_notread <= 1'b0;
            o_m0_data       <= '0;
            o_m1_data       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_pending || m1_pending) begin
                        state <= ST_ISSUE;
                        if (grant_m1) begin
                            o_owner         <= M_AUX;
                            o_bus_data      <= m1_buf_data;
                            o_bus_address   <= m1_buf_address;
                            o_bhw           <= m1_buf_bhw;
                            o_write_notread <= m1_buf_wnr;
                        end else begin
                            o_owner         <= M_CPU;
                            o_bus_data      <= m0_buf_data;
                            o_bus_address   <= m0_buf_address;
                            o_bhw           <= m0_buf_bhw;
                            o_write_notread <= m0_buf_wnr;
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_bus_DV || (wait_cnt == CNT_LAST)) begin
                        state    <= ST_RESP;
                        resp_err <= !i_bus_DV;
                        if (o_owner == M_CPU) begin
                            o_m0_data <= i_bus_DV ? i_bus_data : BUS_TIMEOUT_DATA;
                        end else begin
                            o_m1_data <= i_bus_DV ? i_bus_data : BUS_TIMEOUT_DATA;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    resp_err <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes and flags decoded straight from the registered state.
    always_comb begin
        o_bus_DV = (state == ST_ISSUE);
        o_busy   = (state != ST_IDLE);
        o_m0_DV  = m0_clear;
        o_m1_DV  = m1_clear;
        o_m0_err = (m0_clear && resp_err) || m0_drop;
        o_m1_err = (m1_clear && resp_err) || m1_drop;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter that shares the single memory_top request/response bus between the CPU (master 0) and a second bus master such as a DMA or debug loader (master 1). Each master keeps the same pulse-based DV protocol it would use with memory_top directly. The arbiter captures requests, grants in round-robin order and issues one outstanding transaction at a time. It routes the response back to the originating master and enforces a response timeout so a dead slave cannot hang the bus.

## Interface
- TIMEOUT, 256: number of WAIT cycles without i_bus_DV before a transaction is aborted; must be at least 2.
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_m0_data, i_m1_data  in  32  write data from master N.
- i_m0_address, i_m1_address  in  32  byte address from master N.
- i_m0_DV, i_m1_DV  in  1  one-cycle request strobe from master N.
- i_m0_bhw, i_m1_bhw  in  3  byte/half/word select, forwarded unchanged.
- i_m0_write_notread, i_m1_write_notread  in  1  1 = write, 0 = read.
- o_m0_data, o_m1_data  out  32  response data to master N.
- o_m0_DV, o_m1_DV  out  1  one-cycle response strobe to master N.
- o_m0_err, o_m1_err  out  1  one-cycle error flag:
  - with o_mN_DV: timeout;
  - without o_mN_DV: request dropped.
- o_bus_data, o_bus_address  out  32  request fields to memory_top.
- o_bus_DV  out  1  one-cycle request strobe to memory_top.
- o_bhw  out  3  forwarded bhw.
- o_write_notread  out  1  forwarded direction.
- i_bus_data  in  32  response data from memory_top.
- i_bus_DV  in  1  one-cycle response strobe from memory_top. It is pulsed for both reads and writes.
- o_owner  out  1  master that is currently granted, or last granted when idle.
- o_busy  out  1  high in ISSUE, WAIT and RESP.

## Operation
- Per-master one-entry buffer.
  - An i_mN_DV with the buffer empty latches data, address, bhw and write_notread, then sets pending.
  - An i_mN_DV with pending already set is discarded. The arbiter pulses o_mN_err for one cycle, one cycle later, with o_mN_DV low. The buffered request is unaffected.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any pending, select the winner and load o_bus_* from its buffer, then go to ISSUE. Winner rules:
    - only one pending: that master wins;
    - both pending: the master that is not o_owner wins.
  - ISSUE: o_bus_DV=1 for exactly one cycle; clear the WAIT counter; go to WAIT.
  - WAIT: a sampled i_bus_DV captures i_bus_data and goes to RESP with err=0. Otherwise the counter increments. At counter == TIMEOUT-1 with no i_bus_DV, the FSM captures 32'hDEADBEEF and goes to RESP with err=1. If i_bus_DV arrives on the final cycle, the normal response wins.
  - RESP: pulse o_mN_DV for one cycle for the owner, with captured data and err; clear the owner's pending; go to IDLE.
- i_bus_DV outside WAIT is ignored.
- o_bus_data, o_bus_address, o_bhw and o_write_notread are registered. They are stable from ISSUE through RESP and hold their last value in IDLE.
- o_mN_data holds its last value between responses.
- Reset values:
  - all outputs 0 (o_owner = 1, so master 0 wins the first tie);
  - pending flags cleared, FSM in IDLE, counter 0.
- Reset mid-transaction abandons the transaction:
  - no response is issued to the master;
  - a late i_bus_DV after reset is ignored.

## Timing
- Request i_mN_DV at cycle 0 with the arbiter idle:
  - pending set at end of cycle 0;
  - IDLE grants in cycle 1;
  - o_bus_DV high in cycle 2.
- i_bus_DV in cycle w gives o_mN_DV in cycle w+1.
- Back-to-back transactions: RESP at cycle t, IDLE at t+1, next o_bus_DV at t+2.
- Timeout: ISSUE at t, WAIT t+1..t+TIMEOUT, RESP with err=1 at t+TIMEOUT+1.
- Drop error: offending i_mN_DV at cycle c gives o_mN_err at c+1.
- Only one transaction is outstanding on the bus at any time.

## Structure
- Shared package bus_pkg holds:
  - the state enum;
  - BHW_W=3;
  - BUS_TIMEOUT_DATA=32'hDEADBEEF;
  - the master ID constants M_CPU=0 and M_AUX=1.
- Sub-module bus_req_buffer is the one-entry capture register with pending flag and drop-pulse generation. It is instantiated once per master. The FSM, round-robin logic and response routing live in bus_arbiter.

## Test plan
- m0 read of 0x100 at cycle 0 -> o_bus_DV in cycle 2 with address 0x100 and write_notread 0. Model i_bus_DV in cycle 5 with 0x12345678 -> o_m0_DV in cycle 6 with data 0x12345678 and err 0; o_m1_DV stays 0.
- After reset, m0 and m1 DV in the same cycle -> m0 issued first. m1's o_bus_DV follows 2 cycles after m0's RESP. A repeated simultaneous pair then grants m0 again, because o_owner=1.
- m1 write to 0x2004 with bhw 3'b001 and data 0xAB -> o_bus_address 0x2004, o_bhw 001, o_bus_data 0xAB, o_write_notread 1, o_owner 1. i_bus_DV -> o_m1_DV.
- TIMEOUT=16, no i_bus_DV -> o_m0_DV and o_m0_err 17 cycles after ISSUE, with data 0xDEADBEEF. The next transaction completes normally.
- m0 issues a second DV while pending -> o_m0_err without o_m0_DV one cycle later. The first request completes with its original address and data.
- i_rst asserted during WAIT -> all outputs 0 immediately. A following i_bus_DV produces no o_m0_DV, and the bus stays idle.
